k005297_cyclecmp: RTL and testbench
===================================

Name: k005297_cyclecmp

Overview:
- Downstream consumer of the serial cycle counter in the 005297 bubble controller.
- Deserialises the LSB-first counter stream once per ROT20 frame and publishes the parallel cycle value.
- Compares that value against a loaded target position and raises a match flag for the page-access sequencer.
- Runs on the CLK2M clock-enable grid, in lockstep with the counter it listens to.

Parameters:
- CW, 10, cycle counter width in bits; the stream occupies ROT20 phases 1..CW. CW must be 10 or less.

Ports:
- i_MCLK  in  1  master clock.
- i_RST  in  1  reset, asynchronous, active-high.
- i_CLK2M_PCEN_n  in  1  active-low clock enable; all state advances only on ticks where this is 0.
- i_ROT20_n  in  20  active-low one-hot frame phase.
- i_CYCLECNTR_LSB  in  1  serial counter bit stream.
- i_TARGET  in  CW  target cycle value.
- i_TARGET_LD  in  1  load request for i_TARGET.
- i_ARM  in  1  level request to search for the target.
- o_CYCLE_VALUE  out  CW  last complete deserialised value.
- o_VALUE_VALID  out  1  high for one tick per accepted frame.
- o_MATCH  out  1  sticky match flag.
- o_MATCH_PULSE  out  1  one-tick match strobe.
- o_BUSY  out  1  high while in state ARMED.
- o_TIMEOUT  out  1  search timeout (see Optional Feature).

Behaviour:
- Tick: an MCLK posedge with i_CLK2M_PCEN_n=0. Nothing changes between ticks.
- Phase decode: a tick has phase p when exactly one bit i_ROT20_n[p] is 0. Zero or multiple low bits give phase "none".
- Capture, phase p in 1..CW:
  - Sample i_CYCLECNTR_LSB into shift bit p-1.
  - This is the counter's pre-shift LSB, so the value arrives LSB first.
- Integrity:
  - An internal expected-phase register follows the sequence 1, 2, ..., CW.
  - Any capture-window tick whose phase is not the expected one marks the frame bad.
  - A phase-0 tick clears the bad flag and sets the expected phase to 1.
- Publish, on the tick with phase CW+1:
  - Frame good: o_CYCLE_VALUE <= shift register and o_VALUE_VALID <= 1.
  - Frame bad: no update and no valid pulse.
  - o_VALUE_VALID returns to 0 on the next tick.
- Latency: the last bit is sampled at phase CW; the value is visible after the phase CW+1 tick. That is one tick of latency.
- Target register:
  - Loaded from i_TARGET on a tick with i_TARGET_LD=1, in states IDLE and MATCHED only.
  - Ignored in ARMED; the target is frozen during a search.
- FSM states: IDLE, ARMED, MATCHED, plus TIMEOUT when the optional feature is enabled.
  - IDLE -> ARMED: tick with i_ARM=1. If i_TARGET_LD=1 on the same tick, the load completes first and the search uses the new target.
  - ARMED -> MATCHED: good publish with the new value equal to the target. Same tick: o_MATCH <= 1 and o_MATCH_PULSE <= 1 for one tick.
  - ARMED -> IDLE: tick with i_ARM=0 (abort). No match is flagged, even if a matching publish occurs on that same tick; abort wins.
  - MATCHED -> IDLE: tick with i_ARM=0. o_MATCH <= 0 on that tick.
- o_BUSY is 1 exactly in ARMED.
- A match is evaluated only on a fresh publish. A stale o_CYCLE_VALUE equal to the target at arm time does not match.
- Counter wrap (all ones to 0) needs no special handling; the comparison is plain CW-bit equality.
- Reset:
  - All outputs 0, state IDLE, target 0, shift register 0.
  - Expected phase is set to "none", so the first partial frame after reset is discarded.
  - Reset mid-frame discards that frame.

Optional Feature:
- Macro: K005297_CYCLECMP_TIMEOUT_EN.
- Enabled:
  - An 11-bit search counter clears on entry to ARMED and increments on each good publish that does not match.
  - When it reaches 1025, the FSM goes ARMED -> TIMEOUT and sets o_TIMEOUT <= 1. This is one full counter revolution plus one frame.
  - TIMEOUT -> IDLE on i_ARM=0, clearing o_TIMEOUT.
  - o_BUSY is 0 in TIMEOUT.
- Disabled: no search counter and no TIMEOUT state; o_TIMEOUT is constant 0.

Test Plan:
- Reset then clean frames carrying counter values 0x001, 0x002, 0x003: o_CYCLE_VALUE steps 0x001, 0x002, 0x003, with one o_VALUE_VALID tick per frame at phase 11.
- Target 0x155 loaded, i_ARM=1, stream 0x153..0x156: o_BUSY=1 until the 0x155 publish, then o_MATCH_PULSE for one tick; o_MATCH stays 1 and o_BUSY=0 until i_ARM=0.
- Frame with phase 5 skipped, or phases 4 and 5 low together: no o_VALUE_VALID and o_CYCLE_VALUE unchanged. The next clean frame publishes normally.
- Armed on target 0x3FF, then i_TARGET_LD with 0x000: the load is ignored. Stream 0x3FE, 0x3FF, 0x000 matches at 0x3FF, exercising the wrap.
- i_ARM dropped on the same tick as a matching publish: state goes to IDLE and neither o_MATCH nor o_MATCH_PULSE asserts.
- With K005297_CYCLECMP_TIMEOUT_EN, armed on an unreachable target with the stream stuck at 0x000: o_TIMEOUT=1 after the 1025th publish; i_ARM=0 clears it. Without the macro, o_TIMEOUT stays 0 throughout.

Source files
------------

// File: rtl/k005297_cyclecmp.sv
`default_nettype none
// =============================================================================
// Module : k005297_cyclecmp
// Brief  : Deserialises the serial cycle counter once per ROT20 frame and
//          matches the value against a target. K005297_CYCLECMP_TIMEOUT_EN
//          adds a search timeout.
// Rev    : 1.0
// =============================================================================
module k005297_cyclecmp #(
    parameter int CW = 10
) (
    input  logic          i_MCLK,
    input  logic          i_RST,
    input  logic          i_CLK2M_PCEN_n,
    input  logic [19:0]   i_ROT20_n,
    input  logic          i_CYCLECNTR_LSB,
    input  logic [CW-1:0] i_TARGET,
    input  logic          i_TARGET_LD,
    input  logic          i_ARM,
    output logic [CW-1:0] o_CYCLE_VALUE,
    output logic          o_VALUE_VALID,
    output logic          o_MATCH,
    output logic          o_MATCH_PULSE,
    output logic          o_BUSY,
    output logic          o_TIMEOUT
);
    localparam logic [4:0] c_PH_NONE = 5'd31;
    localparam logic [4:0] c_PH_LAST = 5'(CW);
    localparam logic [4:0] c_PH_PUB  = 5'(CW + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_MATCHED = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_tick;
    logic [19:0]   w_low;
    logic [4:0]    w_phase;
    logic          w_cap;
    logic          w_pub_good;
    logic          w_match_evt;
    logic [CW-1:0] r_shift;
    logic [CW-1:0] r_value;
    logic [CW-1:0] r_target;
    logic [4:0]    r_exp;
    logic          r_bad;
    logic          r_valid;
    logic          r_match_pulse;
`ifdef K005297_CYCLECMP_TIMEOUT_EN
    logic [10:0]   r_cnt;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
`endif

    assign w_tick = ~i_CLK2M_PCEN_n;
    assign w_low  = ~i_ROT20_n;

    // Exactly one low ROT20 line names the phase; anything else is "none".
    always_comb begin
        w_phase = c_PH_NONE;
        if ((w_low != 20'd0) && ((w_low & (w_low - 20'd1)) == 20'd0)) begin
            for (int i = 0; i < 20; i++) begin
                if (w_low[i]) w_phase = 5'(i);
            end
        end
    end

    assign w_cap      = (w_phase >= 5'd1) && (w_phase <= c_PH_LAST);
    // A frame publishes only if every capture phase arrived in order.
    assign w_pub_good = (w_phase == c_PH_PUB) && !r_bad && (r_exp == c_PH_PUB);

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            r_shift <= '0;
            r_value <= '0;
            r_exp   <= c_PH_NONE;
            r_bad   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_tick) begin
            r_valid <= w_pub_good;
            if (w_phase == 5'd0) begin
                r_exp <= 5'd1;
                r_bad <= 1'b0;
            end else if (w_cap) begin
                for (int i = 0; i < CW; i++) begin
                    if (w_phase == 5'(i + 1)) r_shift[i] <= i_CYCLECNTR_LSB;
                end
                if (w_phase == r_exp) r_exp <= r_exp + 5'd1;
                else                  r_bad <= 1'b1;
            end else if (w_phase == c_PH_PUB) begin
                if (w_pub_good) r_value <= r_shift;
                r_exp <= c_PH_NONE;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_match_evt = 1'b0;
`ifdef K005297_CYCLECMP_TIMEOUT_EN
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_ARM) begin
                    w_next = S_ARMED;
`ifdef K005297_CYCLECMP_TIMEOUT_EN
                    w_cnt_clr = 1'b1;
`endif
                end
            end
            S_ARMED: begin
                // Abort takes priority over a match on the same tick.
                if (!i_ARM) begin
                    w_next = S_IDLE;
                end else if (w_pub_good && (r_shift == r_target)) begin
                    w_next      = S_MATCHED;
                    w_match_evt = 1'b1;
                end
`ifdef K005297_CYCLECMP_TIMEOUT_EN
                else if (w_pub_good) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == 11'd1024) w_next = S_TIMEOUT;
                end
`endif
            end
            default: begin
                if (!i_ARM) w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            r_state       <= S_IDLE;
            r_match_pulse <= 1'b0;
            r_target      <= '0;
        end else if (w_tick) begin
            r_state       <= w_next;
            r_match_pulse <= w_match_evt;
            if (i_TARGET_LD && ((r_state == S_IDLE) || (r_state == S_MATCHED)))
                r_target <= i_TARGET;
        end
    end

`ifdef K005297_CYCLECMP_TIMEOUT_EN
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            r_cnt <= 11'd0;
        end else if (w_tick) begin
            if (w_cnt_clr)      r_cnt <= 11'd0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 11'd1;
        end
    end
    assign o_TIMEOUT = (r_state == S_TIMEOUT);
`else
    assign o_TIMEOUT = 1'b0;
`endif

    assign o_CYCLE_VALUE = r_value;
    assign o_VALUE_VALID = r_valid;
    assign o_MATCH       = (r_state == S_MATCHED);
    assign o_MATCH_PULSE = r_match_pulse;
    assign o_BUSY        = (r_state == S_ARMED);

endmodule
`default_nettype wire

// File: tb/tb_k005297_cyclecmp.sv
`default_nettype none
// =============================================================================
// Module : tb_k005297_cyclecmp
// Brief  : Self-checking bench for k005297_cyclecmp with randomised frames.
// Rev    : 1.0
// =============================================================================
module tb_k005297_cyclecmp;
    localparam int          CW   = 10;
    localparam logic [19:0] NONE = 20'hFFFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          pcen_n = 1'b1;
    logic [19:0]   rot_n = NONE;
    logic          lsb = 1'b0;
    logic [CW-1:0] target = '0;
    logic          target_ld = 1'b0;
    logic          arm = 1'b0;
    logic [CW-1:0] cycle_value;
    logic          value_valid, match, match_pulse, busy, timeout;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [CW-1:0] m_value;

    always #5 clk = ~clk;

    k005297_cyclecmp #(.CW(CW)) dut (
        .i_MCLK          (clk),
        .i_RST           (rst),
        .i_CLK2M_PCEN_n  (pcen_n),
        .i_ROT20_n       (rot_n),
        .i_CYCLECNTR_LSB (lsb),
        .i_TARGET        (target),
        .i_TARGET_LD     (target_ld),
        .i_ARM           (arm),
        .o_CYCLE_VALUE   (cycle_value),
        .o_VALUE_VALID   (value_valid),
        .o_MATCH         (match),
        .o_MATCH_PULSE   (match_pulse),
        .o_BUSY          (busy),
        .o_TIMEOUT       (timeout)
    );

    // Random non-tick cycles with junk on the inputs precede every tick.
    task automatic do_tick(input logic [19:0] rn, input logic b);
        int gap;
        gap = $urandom_range(0, 1);
        for (int g = 0; g < gap; g++) begin
            pcen_n = 1'b1; rot_n = 20'($urandom); lsb = 1'($urandom);
            @(posedge clk); #1;
        end
        pcen_n = 1'b0; rot_n = rn; lsb = b;
        @(posedge clk); #1;
        pcen_n = 1'b1;
    endtask

    // kind 0: clean, 1: phase 5 skipped, 2: phases 4 and 5 low together
    task automatic send_frame(input logic [CW-1:0] v, input int kind, input int pfirst,
                              input int plast, input int drop_p,
                              output int n_valid, output int vphase, output int n_pulse);
        logic [19:0]   rn;
        logic          b;
        logic [CW-1:0] vs;
        vs = v; n_valid = 0; vphase = -1; n_pulse = 0;
        for (int p = pfirst; p <= plast; p++) begin
            if (p >= 1 && p <= CW) begin b = vs[0]; vs = vs >> 1; end
            else b = 1'($urandom);
            if (kind == 1 && p == 5) continue;
            rn = ~(20'd1 << p);
            if (kind == 2 && p == 4) rn = ~(20'd3 << 4);
            if (p == drop_p) arm = 1'b0;
            do_tick(rn, b);
            if (value_valid === 1'b1) begin n_valid++; vphase = p; end
            if (match_pulse === 1'b1) n_pulse++;
        end
    endtask

    task automatic arm_on(input logic [CW-1:0] t);
        target = t; target_ld = 1'b1; arm = 1'b1;
        do_tick(NONE, 1'b0);
        target_ld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cycle_value !== '0) begin n_errors++; $display("FAIL reset_value: got %0h expected 0", cycle_value); end
        n_checks++; if ({value_valid, match, match_pulse, busy, timeout} !== 5'b0) begin
            n_errors++; $display("FAIL reset_flags: got %05b expected 00000", {value_valid, match, match_pulse, busy, timeout}); end
        rst = 1'b0;
        m_value = '0;
    endtask

    task automatic test_publish();
        logic [CW-1:0] vals[$];
        int nv, vp, np;
        vals = '{10'h001, 10'h002, 10'h003};
        for (int i = 0; i < 5; i++) vals.push_back(CW'($urandom));
        foreach (vals[i]) begin
            send_frame(vals[i], 0, 0, 19, -1, nv, vp, np);
            m_value = vals[i];
            n_checks++; if (nv !== 1 || vp !== CW + 1) begin n_errors++;
                $display("FAIL publish_valid: got %0d pulses at phase %0d expected 1 at %0d", nv, vp, CW + 1); end
            n_checks++; if (cycle_value !== m_value) begin n_errors++;
                $display("FAIL publish_value: got %0h expected %0h", cycle_value, m_value); end
        end
    endtask

    task automatic test_bad_frame();
        int nv, vp, np;
        logic [CW-1:0] v;
        for (int kind = 1; kind <= 2; kind++) begin
            v = m_value + CW'($urandom_range(1, 500));
            send_frame(v, kind, 0, 19, -1, nv, vp, np);
            n_checks++; if (nv !== 0) begin n_errors++; $display("FAIL bad_frame_valid kind %0d: got %0d expected 0", kind, nv); end
            n_checks++; if (cycle_value !== m_value) begin n_errors++;
                $display("FAIL bad_frame_value kind %0d: got %0h expected %0h", kind, cycle_value, m_value); end
        end
        v = CW'($urandom);
        send_frame(v, 0, 0, 19, -1, nv, vp, np);
        m_value = v;
        n_checks++; if (nv !== 1 || cycle_value !== m_value) begin n_errors++;
            $display("FAIL bad_frame_recover: got %0d/%0h expected 1/%0h", nv, cycle_value, m_value); end
    endtask

    // Stream runs t-2 .. t+1; the match lands on the third frame.
    task automatic test_match(input logic [CW-1:0] t);
        int nv, vp, np;
        logic [CW-1:0] v;
        arm_on(t);
        n_checks++; if (busy !== 1'b1 || match !== 1'b0) begin n_errors++;
            $display("FAIL match_armed: got busy %0b match %0b expected 1 0", busy, match); end
        for (int k = 0; k < 4; k++) begin
            v = t + CW'(k) - CW'(2);
            send_frame(v, 0, 0, 19, -1, nv, vp, np);
            m_value = v;
            n_checks++; if (np !== (k == 2 ? 1 : 0)) begin n_errors++;
                $display("FAIL match_pulse %0h: got %0d expected %0d", v, np, (k == 2 ? 1 : 0)); end
            n_checks++; if (match !== (k >= 2) || busy !== (k < 2)) begin n_errors++;
                $display("FAIL match_state %0h: got match %0b busy %0b expected %0b %0b", v, match, busy, k >= 2, k < 2); end
        end
        arm = 1'b0;
        do_tick(NONE, 1'b0);
        n_checks++; if (match !== 1'b0 || busy !== 1'b0) begin n_errors++;
            $display("FAIL match_release: got match %0b busy %0b expected 0 0", match, busy); end
    endtask

    task automatic test_target_frozen();
        int nv, vp, np;
        logic [CW-1:0] vals[3];
        vals = '{10'h3FE, 10'h3FF, 10'h000};
        arm_on(10'h3FF);
        target = '0; target_ld = 1'b1;
        do_tick(NONE, 1'b0);
        target_ld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_frame(vals[k], 0, 0, 19, -1, nv, vp, np);
            m_value = vals[k];
            n_checks++; if (np !== (k == 1 ? 1 : 0) || match !== (k >= 1)) begin n_errors++;
                $display("FAIL frozen_target %0h: got pulse %0d match %0b expected %0d %0b", vals[k], np, match, (k == 1 ? 1 : 0), k >= 1); end
        end
        arm = 1'b0;
        do_tick(NONE, 1'b0);
    endtask

    task automatic test_abort();
        int nv, vp, np;
        logic [CW-1:0] t;
        t = CW'($urandom);
        arm_on(t);
        send_frame(t, 0, 0, 19, CW + 1, nv, vp, np);
        m_value = t;
        n_checks++; if (np !== 0 || match !== 1'b0 || busy !== 1'b0) begin n_errors++;
            $display("FAIL abort: got pulse %0d match %0b busy %0b expected 0 0 0", np, match, busy); end
        n_checks++; if (nv !== 1 || cycle_value !== t) begin n_errors++;
            $display("FAIL abort_publish: got %0d/%0h expected 1/%0h", nv, cycle_value, t); end
    endtask

    task automatic test_stale();
        int nv, vp, np;
        logic [CW-1:0] v;
        arm_on(m_value);
        do_tick(NONE, 1'b0);
        n_checks++; if (match !== 1'b0 || busy !== 1'b1) begin n_errors++;
            $display("FAIL stale_arm: got match %0b busy %0b expected 0 1", match, busy); end
        v = m_value + CW'(1);
        send_frame(v, 0, 0, 19, -1, nv, vp, np);
        m_value = v;
        n_checks++; if (np !== 0 || busy !== 1'b1) begin n_errors++;
            $display("FAIL stale_frame: got pulse %0d busy %0b expected 0 1", np, busy); end
        arm = 1'b0;
        do_tick(NONE, 1'b0);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL stale_abort: got busy %0b expected 0", busy); end
    endtask

    task automatic test_reset_midframe();
        int nv, vp, np;
        logic [CW-1:0] v;
        send_frame(CW'($urandom), 0, 0, 6, -1, nv, vp, np);
        rst = 1'b1;
        #2;
        n_checks++; if (cycle_value !== '0) begin n_errors++;
            $display("FAIL async_reset: got %0h expected 0", cycle_value); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_value = '0;
        send_frame(CW'($urandom), 0, 7, 19, -1, nv, vp, np);
        n_checks++; if (nv !== 0 || cycle_value !== m_value) begin n_errors++;
            $display("FAIL midframe_discard: got %0d/%0h expected 0/%0h", nv, cycle_value, m_value); end
        v = CW'($urandom);
        send_frame(v, 0, 0, 19, -1, nv, vp, np);
        m_value = v;
        n_checks++; if (nv !== 1 || cycle_value !== m_value) begin n_errors++;
            $display("FAIL midframe_recover: got %0d/%0h expected 1/%0h", nv, cycle_value, m_value); end
    endtask

    task automatic test_timeout();
        int nv, vp, np, sum_np, sum_nv;
        logic exp_to;
`ifdef K005297_CYCLECMP_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        sum_np = 0; sum_nv = 0;
        arm_on(10'h2AA);
        for (int k = 0; k < 1024; k++) begin
            send_frame('0, 0, 0, 19, -1, nv, vp, np);
            sum_np += np; sum_nv += nv;
        end
        m_value = '0;
        n_checks++; if (sum_np !== 0 || sum_nv !== 1024 || timeout !== 1'b0 || busy !== 1'b1) begin n_errors++;
            $display("FAIL timeout_1024: got pulses %0d valids %0d timeout %0b busy %0b expected 0 1024 0 1", sum_np, sum_nv, timeout, busy); end
        send_frame('0, 0, 0, 19, -1, nv, vp, np);
        n_checks++; if (timeout !== exp_to || busy !== !exp_to) begin n_errors++;
            $display("FAIL timeout_1025: got timeout %0b busy %0b expected %0b %0b", timeout, busy, exp_to, !exp_to); end
        arm = 1'b0;
        do_tick(NONE, 1'b0);
        n_checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin n_errors++;
            $display("FAIL timeout_clear: got timeout %0b busy %0b expected 0 0", timeout, busy); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_publish();
        test_bad_frame();
        test_match(10'h155);
        test_match(CW'($urandom));
        test_target_frozen();
        test_abort();
        test_stale();
        test_reset_midframe();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
